// File: rtl/cr_huf_comp_is_counter_pp.sv
// rtl/cr_huf_comp_is_counter_pp.sv - ping-pong symbol-frequency histogram with sparse valid/ready drain
module cr_huf_comp_is_counter_pp #(
  parameter int NUM_IN_SYMBOLS   = 4,
  parameter int DAT_WIDTH        = 10,
  parameter int CNT_WIDTH        = 3,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int MAX_NUM_SYM_USED = 576,
  parameter int SEQID_WIDTH      = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_IN_SYMBOLS-1:0]           in_vld,
  input  logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0] in_sym,
  input  logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0] in_cnt,
  input  logic                                in_eob,
  input  logic [SEQID_WIDTH-1:0]              in_seq_id,
  output logic                                in_rdy,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [DAT_WIDTH-1:0]                out_sym,
  output logic [SYM_FREQ_WIDTH-1:0]           out_freq,
  output logic                                out_last,
  output logic                                out_empty,
  output logic                                out_sat,
  output logic [SEQID_WIDTH-1:0]              out_seq_id,
  output logic [DAT_WIDTH-1:0]                out_sym_lo,
  output logic [DAT_WIDTH-1:0]                out_sym_hi
);

  // Sum width leaves room for the old frequency plus up to 8 lanes of max count.
  localparam int SUM_W = SYM_FREQ_WIDTH + CNT_WIDTH + 4;
  localparam logic [DAT_WIDTH:0]      SYM_LIMIT = (DAT_WIDTH+1)'(MAX_NUM_SYM_USED);
  localparam logic [SYM_FREQ_WIDTH-1:0] FREQ_MAX = {SYM_FREQ_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  logic [SYM_FREQ_WIDTH-1:0] mem [2][MAX_NUM_SYM_USED];

  logic [1:0]             bank_full;
  logic [1:0]             bank_sat;
  logic [1:0]             bank_seen;
  logic [SEQID_WIDTH-1:0] bank_seq [2];
  logic [DAT_WIDTH-1:0]   bank_lo  [2];
  logic [DAT_WIDTH-1:0]   bank_hi  [2];
  logic                   fptr;
  logic                   dptr;

  logic [DAT_WIDTH-1:0]   cur_lo;
  logic [DAT_WIDTH-1:0]   cur_hi;
  logic                   cur_sat;
  logic                   cur_seen;

  state_t                 state;
  state_t                 state_nxt;
  logic [DAT_WIDTH-1:0]   ptr;

  logic [NUM_IN_SYMBOLS-1:0] lane_ok;
  logic [NUM_IN_SYMBOLS-1:0] lane_wr;
  logic [NUM_IN_SYMBOLS-1:0] lane_clamp;
  logic [DAT_WIDTH-1:0]      lane_sym [NUM_IN_SYMBOLS];
  logic [SYM_FREQ_WIDTH-1:0] lane_new [NUM_IN_SYMBOLS];
  logic [SUM_W-1:0]          acc;
  logic [SUM_W-1:0]          total;
  logic [DAT_WIDTH-1:0]      idx;
  logic [DAT_WIDTH-1:0]      beat_lo;
  logic [DAT_WIDTH-1:0]      beat_hi;
  logic                      beat_sat;
  logic                      beat_seen;

  logic                      free_now;
  logic                      in_take;
  logic                      rd_load;
  logic [DAT_WIDTH-1:0]      rd_idx;
  logic [SYM_FREQ_WIDTH-1:0] rd_data;

  // The last accepted beat of a block releases its bank in the same cycle.
  assign free_now = (state == STREAM) && out_vld && out_rdy && out_last;
  assign in_rdy   = !rst && (!bank_full[fptr] || (free_now && (dptr == fptr)));
  assign in_take  = in_rdy && ((|in_vld) || in_eob);

  // Per-lane qualification, duplicate merging (first lane of a symbol writes) and saturating update.
  always_comb begin
    lane_ok    = '0;
    lane_wr    = '0;
    lane_clamp = '0;
    acc        = '0;
    total      = '0;
    idx        = '0;
    for (int i = 0; i < NUM_IN_SYMBOLS; i++) begin
      lane_sym[i] = in_sym[i*DAT_WIDTH +: DAT_WIDTH];
      lane_ok[i]  = in_vld[i] && (in_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '0) &&
                    ({1'b0, lane_sym[i]} < SYM_LIMIT);
    end
    for (int i = 0; i < NUM_IN_SYMBOLS; i++) begin
      acc        = '0;
      lane_wr[i] = lane_ok[i];
      for (int j = 0; j < NUM_IN_SYMBOLS; j++) begin
        if (lane_ok[j] && (lane_sym[j] == lane_sym[i])) begin
          acc = acc + SUM_W'(in_cnt[j*CNT_WIDTH +: CNT_WIDTH]);
          if (j < i) lane_wr[i] = 1'b0;
        end
      end
      idx           = lane_ok[i] ? lane_sym[i] : '0;
      total         = SUM_W'(mem[fptr][idx]) + acc;
      lane_clamp[i] = lane_wr[i] && (total > SUM_W'(FREQ_MAX));
      lane_new[i]   = (total > SUM_W'(FREQ_MAX)) ? FREQ_MAX : total[SYM_FREQ_WIDTH-1:0];
    end
  end

  // Running min/max, seen and sticky saturation for the block currently being filled.
  always_comb begin
    beat_seen = cur_seen;
    beat_lo   = cur_lo;
    beat_hi   = cur_hi;
    beat_sat  = cur_sat | (|lane_clamp);
    for (int i = 0; i < NUM_IN_SYMBOLS; i++) begin
      if (lane_ok[i]) begin
        if (!beat_seen || (lane_sym[i] < beat_lo)) beat_lo = lane_sym[i];
        if (!beat_seen || (lane_sym[i] > beat_hi)) beat_hi = lane_sym[i];
        beat_seen = 1'b1;
      end
    end
  end

  // Drain read port: first entry on LOAD, next entry each time a non-last beat is taken.
  always_comb begin
    rd_load = ((state == LOAD) && bank_seen[dptr]) ||
              ((state == STREAM) && out_vld && out_rdy && !out_last);
    rd_idx  = (state == LOAD) ? bank_lo[dptr] : ptr;
    rd_data = mem[dptr][rd_idx];
  end

  // Drain next-state: start as soon as the drain bank is full or is being closed this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bank_full[dptr] || (in_take && in_eob && (fptr == dptr))) state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      STREAM:  if (free_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count storage: drained entries are zeroed as they are read, counted lanes are written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < MAX_NUM_SYM_USED; s++)
          mem[b][s] <= '0;
    end else begin
      if (rd_load) mem[dptr][rd_idx] <= '0;
      if (in_take)
        for (int i = 0; i < NUM_IN_SYMBOLS; i++)
          if (lane_wr[i]) mem[fptr][lane_sym[i]] <= lane_new[i];
    end
  end

  // Bank ownership and block metadata; a close in the freeing bank wins over the free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full   <= '0;
      bank_sat    <= '0;
      bank_seen   <= '0;
      bank_seq[0] <= '0;
      bank_seq[1] <= '0;
      bank_lo[0]  <= '0;
      bank_lo[1]  <= '0;
      bank_hi[0]  <= '0;
      bank_hi[1]  <= '0;
      fptr        <= 1'b0;
      dptr        <= 1'b0;
      cur_lo      <= '0;
      cur_hi      <= '0;
      cur_sat     <= 1'b0;
      cur_seen    <= 1'b0;
    end else begin
      if (free_now) begin
        bank_full[dptr] <= 1'b0;
        dptr            <= ~dptr;
      end
      if (in_take) begin
        if (in_eob) begin
          bank_full[fptr] <= 1'b1;
          bank_seq[fptr]  <= in_seq_id;
          bank_lo[fptr]   <= beat_lo;
          bank_hi[fptr]   <= beat_hi;
          bank_sat[fptr]  <= beat_sat;
          bank_seen[fptr] <= beat_seen;
          fptr            <= ~fptr;
          cur_lo          <= '0;
          cur_hi          <= '0;
          cur_sat         <= 1'b0;
          cur_seen        <= 1'b0;
        end else begin
          cur_lo   <= beat_lo;
          cur_hi   <= beat_hi;
          cur_sat  <= beat_sat;
          cur_seen <= beat_seen;
        end
      end
    end
  end

  // Drain state and registered output beat; the beat holds while out_vld && !out_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      out_vld    <= 1'b0;
      out_sym    <= '0;
      out_freq   <= '0;
      out_last   <= 1'b0;
      out_empty  <= 1'b0;
      out_sat    <= 1'b0;
      out_seq_id <= '0;
      out_sym_lo <= '0;
      out_sym_hi <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          out_vld    <= 1'b1;
          out_seq_id <= bank_seq[dptr];
          out_sat    <= bank_sat[dptr];
          if (bank_seen[dptr]) begin
            out_sym    <= bank_lo[dptr];
            out_freq   <= rd_data;
            out_last   <= (bank_lo[dptr] == bank_hi[dptr]);
            out_empty  <= 1'b0;
            out_sym_lo <= bank_lo[dptr];
            out_sym_hi <= bank_hi[dptr];
            ptr        <= bank_lo[dptr] + 1'b1;
          end else begin
            out_sym    <= '0;
            out_freq   <= '0;
            out_last   <= 1'b1;
            out_empty  <= 1'b1;
            out_sym_lo <= '0;
            out_sym_hi <= '0;
          end
        end
        STREAM: begin
          if (out_vld && out_rdy) begin
            if (out_last) begin
              out_vld <= 1'b0;
            end else begin
              out_sym  <= ptr;
              out_freq <= rd_data;
              out_last <= (ptr == out_sym_hi);
              ptr      <= ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_is_counter_pp.sv
// tb/tb_cr_huf_comp_is_counter_pp.sv - self-checking bench for cr_huf_comp_is_counter_pp
module tb_cr_huf_comp_is_counter_pp;

  localparam int N    = 4;
  localparam int DW   = 10;
  localparam int CW   = 3;
  localparam int FW   = 4;
  localparam int MS   = 576;
  localparam int SW   = 6;
  localparam int FMAX = (1 << FW) - 1;

  typedef struct {
    int sym; int freq; int last; int empty; int sat; int seq; int lo; int hi;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_vld;
  logic [N*DW-1:0]   in_sym;
  logic [N*CW-1:0]   in_cnt;
  logic              in_eob;
  logic [SW-1:0]     in_seq_id;
  logic              in_rdy;
  logic              out_vld;
  logic              out_rdy;
  logic [DW-1:0]     out_sym;
  logic [FW-1:0]     out_freq;
  logic              out_last;
  logic              out_empty;
  logic              out_sat;
  logic [SW-1:0]     out_seq_id;
  logic [DW-1:0]     out_sym_lo;
  logic [DW-1:0]     out_sym_hi;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  bit    bp_en = 1'b0;

  cr_huf_comp_is_counter_pp #(
    .NUM_IN_SYMBOLS(N), .DAT_WIDTH(DW), .CNT_WIDTH(CW), .SYM_FREQ_WIDTH(FW),
    .MAX_NUM_SYM_USED(MS), .SEQID_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sym(in_sym), .in_cnt(in_cnt),
    .in_eob(in_eob), .in_seq_id(in_seq_id), .in_rdy(in_rdy), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_sym(out_sym), .out_freq(out_freq), .out_last(out_last),
    .out_empty(out_empty), .out_sat(out_sat), .out_seq_id(out_seq_id),
    .out_sym_lo(out_sym_lo), .out_sym_hi(out_sym_hi)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(int sym, int freq, int last, int empty, int sat, int seq, int lo, int hi);
    beat_t b;
    b.sym = sym; b.freq = freq; b.last = last; b.empty = empty;
    b.sat = sat; b.seq = seq; b.lo = lo; b.hi = hi;
    return b;
  endfunction

  function automatic longint pack(beat_t b);
    longint v;
    v = longint'(b.sym);
    v = v * 16 + longint'(b.freq);
    v = v * 2 + longint'(b.last);
    v = v * 2 + longint'(b.empty);
    v = v * 2 + longint'(b.sat);
    v = v * 64 + longint'(b.seq);
    v = v * 1024 + longint'(b.lo);
    v = v * 1024 + longint'(b.hi);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pk(int a, int b, int c, int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [N*CW-1:0] pkc(int a, int b, int c, int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per-block counts from the accepted beats; on eob, the whole expected drain.
  int m_cnt [MS];
  int m_lo, m_hi, m_seen;
  always @(negedge clk) begin
    int sy, cn, sat;
    if (rst) begin
      for (int s = 0; s < MS; s++) m_cnt[s] = 0;
      m_seen = 0; m_lo = 0; m_hi = 0;
      exp_q.delete();
    end else if (((|in_vld) || in_eob) && in_rdy) begin
      for (int i = 0; i < N; i++) begin
        sy = int'(in_sym[i*DW +: DW]);
        cn = int'(in_cnt[i*CW +: CW]);
        if (in_vld[i] && cn != 0 && sy < MS) begin
          m_cnt[sy] += cn;
          if (!m_seen || sy < m_lo) m_lo = sy;
          if (!m_seen || sy > m_hi) m_hi = sy;
          m_seen = 1;
        end
      end
      if (in_eob) begin
        if (!m_seen) begin
          exp_q.push_back(mk(0, 0, 1, 1, 0, int'(in_seq_id), 0, 0));
        end else begin
          sat = 0;
          for (int s = m_lo; s <= m_hi; s++) if (m_cnt[s] > FMAX) sat = 1;
          for (int s = m_lo; s <= m_hi; s++) begin
            exp_q.push_back(mk(s, (m_cnt[s] > FMAX) ? FMAX : m_cnt[s], (s == m_hi) ? 1 : 0,
                               0, sat, int'(in_seq_id), m_lo, m_hi));
            m_cnt[s] = 0;
          end
        end
        m_seen = 0; m_lo = 0; m_hi = 0;
      end
    end
  end

  // Compare process: every accepted drain beat against the model, and hold stability under backpressure.
  beat_t hold_b;
  bit    hold = 1'b0;
  always @(negedge clk) begin
    beat_t a, e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      a = mk(int'(out_sym), int'(out_freq), int'(out_last), int'(out_empty), int'(out_sat),
             int'(out_seq_id), int'(out_sym_lo), int'(out_sym_hi));
      if (hold) begin
        chk("hold_vld", longint'(out_vld), 1);
        chk("hold_data", pack(a), pack(hold_b));
      end
      hold = out_vld && !out_rdy;
      hold_b = a;
      if (out_vld && out_rdy) begin
        chk("beat_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat", pack(a), pack(e));
        end
        log_q.push_back(a);
      end
    end
  end

  always @(posedge clk) if (bp_en) begin
    #1;
    out_rdy = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [N-1:0] v, input logic [N*DW-1:0] s, input logic [N*CW-1:0] c,
                      input bit eob, input int seq);
    int w = 0;
    in_vld = v; in_sym = s; in_cnt = c; in_eob = eob; in_seq_id = SW'(seq);
    @(negedge clk);
    while (!in_rdy && w < 300) begin w++; @(negedge clk); end
    chk("send_accept", longint'(in_rdy), 1);
    @(posedge clk); #1;
    in_vld = '0; in_eob = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_vld) && w < 2000) begin w++; @(negedge clk); end
    chk("drain_done", longint'(exp_q.size() == 0 && !out_vld), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, total, sum;
    int seqs[$];
    rst = 1'b1; in_vld = '0; in_sym = '0; in_cnt = '0; in_eob = 1'b0; in_seq_id = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_in_rdy", longint'(in_rdy), 0);
    chk("rst_out_sym", longint'(out_sym), 0);
    chk("rst_out_freq", longint'(out_freq), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", longint'(in_rdy), 1);
    @(posedge clk); #1;

    // Single block, duplicate lanes merged, out-of-alphabet lane ignored, latency.
    log_q.delete();
    send(4'hF, pk(5, 7, 5, 600), pkc(3, 1, 2, 4), 0, 0);
    send(4'h0, pk(0, 0, 0, 0), pkc(0, 0, 0, 0), 1, 1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_vld && lat == 0) lat = k;
    end
    chk("t1_latency", lat, 2);
    wait_drain();
    chk("t1_nbeats", log_q.size(), 3);
    chk("t1_beat0", pack(log_q[0]), pack(mk(5, 5, 0, 0, 0, 1, 5, 7)));
    chk("t1_beat1", pack(log_q[1]), pack(mk(6, 0, 0, 0, 0, 1, 5, 7)));
    chk("t1_beat2", pack(log_q[2]), pack(mk(7, 1, 1, 0, 0, 1, 5, 7)));

    // Saturation on a single-symbol block.
    log_q.delete();
    send(4'b0111, pk(3, 3, 3, 9), pkc(7, 7, 6, 5), 1, 2);
    wait_drain();
    chk("t2_nbeats", log_q.size(), 1);
    chk("t2_sat_beat", pack(log_q[0]), pack(mk(3, 15, 1, 0, 1, 2, 3, 3)));

    // Empty block.
    log_q.delete();
    send(4'h0, pk(0, 0, 0, 0), pkc(0, 0, 0, 0), 1, 3);
    wait_drain();
    chk("t3_nbeats", log_q.size(), 1);
    chk("t3_empty_beat", pack(log_q[0]), pack(mk(0, 0, 1, 1, 0, 3, 0, 0)));

    // Ping-pong under backpressure; block 3 closes on the cycle bank 0 frees.
    log_q.delete();
    out_rdy = 1'b0;
    send(4'hF, pk(10, 11, 12, 10), pkc(1, 2, 3, 4), 1, 1);
    send(4'b0011, pk(11, 20, 0, 0), pkc(1, 1, 0, 0), 0, 2);
    send(4'h0, pk(0, 0, 0, 0), pkc(0, 0, 0, 0), 1, 2);
    @(negedge clk);
    chk("t4_in_rdy_low", longint'(in_rdy), 0);
    @(posedge clk); #1;
    fork
      send(4'hF, pk(10, 12, 12, 30), pkc(2, 2, 2, 2), 1, 3);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_in_rdy_still_low", longint'(in_rdy), 0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    wait_drain();
    seqs.delete();
    foreach (log_q[i]) if (log_q[i].last) seqs.push_back(log_q[i].seq);
    chk("t4_nblocks", seqs.size(), 3);
    chk("t4_seq0", seqs[0], 1);
    chk("t4_seq1", seqs[1], 2);
    chk("t4_seq2", seqs[2], 3);
    chk("t4_reuse_sym10", pack(log_q[log_q.size()-21]), pack(mk(10, 2, 0, 0, 0, 3, 10, 30)));

    // 50-symbol drain with random backpressure; frequency total preserved.
    log_q.delete();
    total = 0;
    bp_en = 1'b1;
    for (int b = 0; b < 13; b++) begin
      logic [N*DW-1:0] s;
      logic [N*CW-1:0] c;
      for (int i = 0; i < N; i++) begin
        s[i*DW +: DW] = DW'(100 + (b*4 + i) % 50);
        c[i*CW +: CW] = CW'(1 + (b + i) % 3);
        total += 1 + (b + i) % 3;
      end
      send(4'hF, s, c, (b == 12), 5);
    end
    wait_drain();
    bp_en = 1'b0;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    sum = 0;
    foreach (log_q[i]) sum += log_q[i].freq;
    chk("t5_nbeats", log_q.size(), 50);
    chk("t5_freq_sum", sum, total);
    chk("t5_first_sym", log_q[0].sym, 100);
    chk("t5_last_sym", log_q[49].sym, 149);

    // Reset in the middle of a drain, then a fresh block counts from zero.
    send(4'hF, pk(40, 41, 42, 43), pkc(1, 1, 1, 1), 0, 0);
    send(4'hF, pk(44, 45, 46, 47), pkc(1, 1, 1, 1), 1, 6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_vld", longint'(out_vld), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_in_rdy", longint'(in_rdy), 1);
    chk("t6_out_vld", longint'(out_vld), 0);
    @(posedge clk); #1;
    log_q.delete();
    send(4'hF, pk(41, 41, 50, 40), pkc(2, 3, 1, 1), 1, 7);
    wait_drain();
    chk("t6_nbeats", log_q.size(), 11);
    chk("t6_beat0", pack(log_q[0]), pack(mk(40, 1, 0, 0, 0, 7, 40, 50)));
    chk("t6_beat1", pack(log_q[1]), pack(mk(41, 5, 0, 0, 0, 7, 40, 50)));

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
